// File: rtl/mux_n_to_1_pipe.sv
// N-to-1 select captured into a two-entry skid buffer; MUX_SEL_CHECK_EN zeroes out-of-range picks and raises sticky sel_err.
// Latency: 1 cycle from acceptance to out_data when empty; 1 word/cycle sustained.
// Backpressure: in_ready is registered and drops only when both entries hold words.
module mux_n_to_1_pipe #(
  parameter int WIDTH = 5,
  parameter int N_IN  = 2,
  parameter int SEL_W = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      select,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] sel_word;
  logic             in_xfer, out_xfer;
`ifdef MUX_SEL_CHECK_EN
  logic             sel_oor;
  logic             sel_err_q, sel_err_d;
`endif

  // Out-of-range selects fall through to input 0 unless the check zeroes them.
  always_comb begin
    sel_word = in_data[WIDTH-1:0];
    for (int k = 1; k < N_IN; k++) begin
      if (int'(select) == k) sel_word = in_data[k*WIDTH +: WIDTH];
    end
`ifdef MUX_SEL_CHECK_EN
    sel_oor = (int'(select) >= N_IN);
    if (sel_oor) sel_word = '0;
`endif
  end

  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = sel_word;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = sel_word;
        end else if (in_xfer) begin
          skid_d  = sel_word;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Derived from the next state so in_ready needs no path from out_ready.
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef MUX_SEL_CHECK_EN
  always_comb sel_err_d = sel_err_q | (in_xfer & sel_oor);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err_q <= 1'b0;
    else        sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

  assign in_ready = in_ready_q;
  assign out_data = main_q;

endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
// Bench for mux_n_to_1_pipe: three instances (2x5b, 3x8b, 4x8b), queue scoreboard fed by an input monitor.
module tb_mux_n_to_1_pipe;

`ifdef MUX_SEL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [9:0]  a_in;  logic [0:0] a_sel; logic [4:0] a_od;
  logic        a_iv, a_ir, a_ov, a_or, a_err;
  logic [23:0] b_in;  logic [1:0] b_sel; logic [7:0] b_od;
  logic        b_iv, b_ir, b_ov, b_or, b_err;
  logic [31:0] c_in;  logic [1:0] c_sel; logic [7:0] c_od;
  logic        c_iv, c_ir, c_ov, c_or, c_err;

  mux_n_to_1_pipe #(.WIDTH(5), .N_IN(2), .SEL_W(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in), .select(a_sel), .in_valid(a_iv),
    .in_ready(a_ir), .out_data(a_od), .out_valid(a_ov), .out_ready(a_or), .sel_err(a_err));
  mux_n_to_1_pipe #(.WIDTH(8), .N_IN(3), .SEL_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in), .select(b_sel), .in_valid(b_iv),
    .in_ready(b_ir), .out_data(b_od), .out_valid(b_ov), .out_ready(b_or), .sel_err(b_err));
  mux_n_to_1_pipe #(.WIDTH(8), .N_IN(4), .SEL_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_in), .select(c_sel), .in_valid(c_iv),
    .in_ready(c_ir), .out_data(c_od), .out_valid(c_ov), .out_ready(c_or), .sel_err(c_err));

  int checks = 0;
  int passes = 0;
  logic [7:0] qa[$], qb[$], qc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic sb(input string nm, input bit have, input logic [7:0] exp, input logic [7:0] act);
    checks++;
    if (!have) $display("FAIL %s: output %0d appeared with no word outstanding", nm, act);
    else if (act !== exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    else passes++;
  endtask

  // Reference: word sel of the flattened bus, out-of-range -> zero (check) or input 0.
  function automatic logic [7:0] ref_word(input logic [63:0] flat, input int sel, input int n, input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    if (sel >= n) return CHK ? 8'd0 : 8'(flat & mask);
    return 8'((flat >> (sel * w)) & mask);
  endfunction

  logic [7:0] mon_e;
  bit         mon_h;
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_ov && a_or) begin
        mon_h = (qa.size() != 0); mon_e = 8'd0;
        if (mon_h) mon_e = qa.pop_front();
        sb("sb_a", mon_h, mon_e, {3'd0, a_od});
      end
      if (b_ov && b_or) begin
        mon_h = (qb.size() != 0); mon_e = 8'd0;
        if (mon_h) mon_e = qb.pop_front();
        sb("sb_b", mon_h, mon_e, b_od);
      end
      if (c_ov && c_or) begin
        mon_h = (qc.size() != 0); mon_e = 8'd0;
        if (mon_h) mon_e = qc.pop_front();
        sb("sb_c", mon_h, mon_e, c_od);
      end
      if (a_iv && a_ir) qa.push_back(ref_word(64'(a_in), int'(a_sel), 2, 5));
      if (b_iv && b_ir) qb.push_back(ref_word(64'(b_in), int'(b_sel), 3, 8));
      if (c_iv && c_ir) qc.push_back(ref_word(64'(c_in), int'(c_sel), 4, 8));
    end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  int sent;
  int cyc;

  initial begin
    rst_n = 1'b0;
    a_in = '0; a_sel = '0; a_iv = 1'b0; a_or = 1'b0;
    b_in = '0; b_sel = '0; b_iv = 1'b0; b_or = 1'b0;
    c_in = '0; c_sel = '0; c_iv = 1'b0; c_or = 1'b0;
    #2;
    chk("rst_ir", a_ir, 0); chk("rst_ov", a_ov, 0);
    chk("rst_od", a_od, 0); chk("rst_err", a_err, 0);
    chk("rst_b_ov", b_ov, 0); chk("rst_c_ir", c_ir, 0);
    #10 rst_n = 1'b1;
    #1 chk("ir_before_first_edge", a_ir, 0);
    step; chk("ir_after_release", a_ir, 1);

    // single-word latency
    a_in = {5'd9, 5'd3}; a_sel = 1'b1; a_iv = 1'b1; a_or = 1'b1;
    step; a_iv = 1'b0;
    chk("lat_ov", a_ov, 1); chk("lat_od", a_od, 9);
    step; chk("lat_ov_one_cycle", a_ov, 0);

    // backpressure
    a_or = 1'b0; a_sel = 1'b0; a_in = {5'd0, 5'd4}; a_iv = 1'b1;
    step; a_in = {5'd0, 5'd7};
    step; a_iv = 1'b0;
    chk("bp_ir_full", a_ir, 0); chk("bp_od", a_od, 4);
    step; chk("bp_hold_od", a_od, 4); chk("bp_hold_ov", a_ov, 1);
    a_or = 1'b1;
    step; chk("bp_second_od", a_od, 7); chk("bp_ir_back", a_ir, 1);
    step; chk("bp_drained", a_ov, 0);

    // simultaneous transfer in ONE
    a_or = 1'b0; a_in = {5'd0, 5'd5}; a_iv = 1'b1;
    step; a_in = {5'd0, 5'd6}; a_or = 1'b1;
    step; a_iv = 1'b0;
    chk("sim_od", a_od, 6); chk("sim_ov", a_ov, 1); chk("sim_ir_one", a_ir, 1);
    step; chk("sim_drained", a_ov, 0);

    // range check, N_IN=3
    b_or = 1'b1; b_in = {8'd33, 8'd22, 8'd11}; b_sel = 2'd3; b_iv = 1'b1;
    step; b_sel = 2'd1;
    chk("rng_od", b_od, CHK ? 0 : 11); chk("rng_err", b_err, CHK);
    step; b_sel = 2'd2;
    chk("rng_od_1", b_od, 22); chk("rng_err_sticky", b_err, CHK);
    step; b_iv = 1'b0;
    chk("rng_od_2", b_od, 33);
    step; chk("rng_err_sticky2", b_err, CHK); chk("rng_drained", b_ov, 0);

    // random streaming, N_IN=4
    sent = 0; cyc = 0;
    while (sent < 100 && cyc < 5000) begin
      c_iv  = ($urandom_range(0, 3) != 0);
      c_in  = $urandom;
      c_sel = 2'($urandom_range(0, 3));
      c_or  = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (c_iv && c_ir) sent++;
      step; cyc++;
    end
    chk("stream_sent", sent, 100);
    c_iv = 1'b0; c_or = 1'b1;
    repeat (4) step;
    chk("stream_queue_empty", qc.size(), 0); chk("stream_ov", c_ov, 0);
    chk("stream_err", c_err, 0);

    // reset while FULL
    a_or = 1'b0; a_sel = 1'b0; a_in = {5'd0, 5'd12}; a_iv = 1'b1;
    step; a_in = {5'd0, 5'd13};
    step; a_iv = 1'b0;
    chk("rst_mid_full", a_ir, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ov", a_ov, 0); chk("rst_mid_od", a_od, 0); chk("rst_mid_ir", a_ir, 0);
    qa.delete(); qb.delete(); qc.delete();
    #3 rst_n = 1'b1;
    step; chk("rst_mid_ir_back", a_ir, 1); chk("rst_mid_ov_after", a_ov, 0);
    a_or = 1'b1;
    repeat (3) begin
      step; chk("rst_no_stale", a_ov, 0);
    end
    chk("final_qa_empty", qa.size(), 0);
    chk("final_qb_empty", qb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
